// File: rtl/heart_seg_sequencer_pkg.sv
// rtl/heart_seg_sequencer_pkg.sv - shared constants for the heart segment sequencer
// Purpose: state encoding, frame table and divider floor shared by the design and the bench.
// Ports: none (package).
package heart_pkg;

  localparam int N_FRAMES = 8;
  localparam int FRAME_W  = 3;
  localparam int DIV_MIN  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE
  } state_e;

  // Heart grow/shrink patterns, {g,f,e,d,c,b,a}; entry 0 is the least significant slot.
  localparam logic [N_FRAMES-1:0][6:0] FRAME_TABLE = {
    7'h08, 7'h36, 7'h3f, 7'h7f, 7'h77, 7'h5c, 7'h63, 7'h40
  };

endpackage

// File: rtl/heart_seg_sequencer_if.sv
// rtl/heart_seg_sequencer_if.sv - control/status bundle of the heart segment sequencer
// Purpose: groups the control pulses and display outputs of the sequencer.
// Ports (master drives): ena, start, stop, pause, step, loop_en, speed_sel[2:0], speed_load
// Ports (slave drives):  segments[6:0], frame_idx[FRAME_W-1:0], frame_tick, state[1:0]
interface heart_seg_sequencer_if;
  import heart_pkg::*;

  logic               ena;
  logic               start;
  logic               stop;
  logic               pause;
  logic               step;
  logic               loop_en;
  logic [2:0]         speed_sel;
  logic               speed_load;
  logic [6:0]         segments;
  logic [FRAME_W-1:0] frame_idx;
  logic               frame_tick;
  logic [1:0]         state;

  modport master (
    output ena, start, stop, pause, step, loop_en, speed_sel, speed_load,
    input  segments, frame_idx, frame_tick, state
  );

  modport slave (
    input  ena, start, stop, pause, step, loop_en, speed_sel, speed_load,
    output segments, frame_idx, frame_tick, state
  );

endinterface

// File: rtl/heart_seg_sequencer_frame_rom.sv
// rtl/heart_seg_sequencer_frame_rom.sv - combinational frame index to segment pattern lookup
// Purpose: maps a frame index onto its heart pattern from the package table.
// Ports: idx (in, FRAME_W) frame index; seg (out, 7) pattern {g,f,e,d,c,b,a}.
module heart_frame_rom
  import heart_pkg::*;
(
  input  logic [FRAME_W-1:0] idx,
  output logic [6:0]         seg
);

  assign seg = FRAME_TABLE[idx];

endmodule

// File: rtl/heart_seg_sequencer.sv
// rtl/heart_seg_sequencer.sv - frame scheduler for the 7-segment heart animation
// Purpose: prescaled frame pacing, run/pause/step/one-shot sequencing, registered segment output.
// Ports: clk, rst (async, active-high); bus (slave modport): control pulses in,
//        segments/frame_idx/frame_tick/state out.
module heart_seg_sequencer
  import heart_pkg::*;
#(
  parameter int PRESCALE_W  = 24,
  parameter int DEFAULT_DIV = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  heart_seg_sequencer_if.slave  bus
);

  localparam logic [PRESCALE_W-1:0] BASE_DIV  = PRESCALE_W'(DEFAULT_DIV);
  localparam logic [PRESCALE_W-1:0] FLOOR_DIV = PRESCALE_W'(DIV_MIN);

  state_e                 state_q, state_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d;
  logic [2:0]             speed_q, speed_d;
  logic                   tick_q, tick_d;
  logic [6:0]             seg_q, seg_d;

  logic [PRESCALE_W-1:0]  div_shift;
  logic [PRESCALE_W-1:0]  div;
  logic                   period_end;
  logic [6:0]             rom_seg;

  heart_frame_rom u_rom (
    .idx (frame_q),
    .seg (rom_seg)
  );

  assign div_shift  = BASE_DIV >> speed_q;
  assign div        = (div_shift < FLOOR_DIV) ? FLOOR_DIV : div_shift;
  // A speed_load in the same cycle discards the partial period, so it also cancels the tick.
  assign period_end = (presc_q >= div - PRESCALE_W'(1)) && !bus.speed_load;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    presc_d = presc_q;
    speed_d = speed_q;
    tick_d  = 1'b0;
    seg_d   = (state_q == S_IDLE) ? 7'd0 : rom_seg;

    if (bus.stop) begin
      state_d = S_IDLE;
      frame_d = '0;
      presc_d = '0;
    end else if (bus.start) begin
      state_d = S_RUN;
      frame_d = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (period_end) begin
            presc_d = '0;
            if ((&frame_q) && !bus.loop_en) begin
              state_d = S_IDLE;
              frame_d = '0;
            end else begin
              frame_d = frame_q + FRAME_W'(1);
              tick_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRESCALE_W'(1);
          end
        end
        S_PAUSE: begin
          if (bus.pause) begin
            state_d = S_RUN;
          end else if (bus.step) begin
            frame_d = frame_q + FRAME_W'(1);
            tick_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (bus.speed_load) begin
      speed_d = bus.speed_sel;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      presc_q <= '0;
      speed_q <= '0;
      tick_q  <= 1'b0;
      seg_q   <= '0;
    end else if (bus.ena) begin
      state_q <= state_d;
      frame_q <= frame_d;
      presc_q <= presc_d;
      speed_q <= speed_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.frame_idx  = frame_q;
  assign bus.frame_tick = tick_q;
  assign bus.state      = state_q;

endmodule
